pulse_meter: RTL and testbench

- Consumer side of the team's count-pulse interface: samples a synchronous pulse/level stream (e.g. a counter's terminal-count output) and counts its rising edges over a programmable gate window of clk cycles.
- Reports the edge count, with a sticky saturation flag, through a valid/ready result handshake.
- Sits downstream of counters/timers for rate checking and frequency measurement.

---
 rtl/pulse_meter_if.sv | 23 ++
 rtl/pulse_meter.sv | 104 ++++++++++
 tb/tb_pulse_meter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pulse_meter_if.sv
// Result handshake of the pulse meter: the meter is the master, the consumer is the slave.
interface pulse_meter_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] result_count;
    logic             result_ovf;

    modport master (
        output result_valid,
        output result_count,
        output result_ovf,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_count,
        input  result_ovf,
        output result_ready
    );
endinterface

// File: rtl/pulse_meter.sv
// Counts rising edges of pulse_in_i over a gated window of clk cycles and
// returns the saturating count plus a sticky overflow flag through a valid/ready handshake.
module pulse_meter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic [WIN_W-1:0] window_len_i,
    input  logic             pulse_in_i,
    output logic             busy_o,
    pulse_meter_if.master    res_if
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StMeasure, StReport} state_e;

    state_e           state_q;
    logic             pulse_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             busy_q;
    logic             valid_q;
    logic [CNT_W-1:0] res_count_q;
    logic             res_ovf_q;
    logic             rise;

    // Count and overflow as they would stand if the current edge is an active one.
    always_comb begin
        rise  = pulse_in_i & ~pulse_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rise) begin
            if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pulse_q     <= 1'b0;
            win_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            pulse_q <= pulse_in_i;
            unique case (state_q)
                StIdle: begin
                    if (start_i && enable_i && (window_len_i != '0)) begin
                        win_q   <= window_len_i;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (enable_i) begin
                        win_q <= win_q - 1'b1;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        // win_q is never 0 here, so this is the last active edge.
                        if (win_q == WIN_W'(1)) begin
                            res_count_q <= cnt_d;
                            res_ovf_q   <= ovf_d;
                            valid_q     <= 1'b1;
                            state_q     <= StReport;
                        end
                    end
                end
                StReport: begin
                    if (res_if.result_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o              = busy_q;
    assign res_if.result_valid = valid_q;
    assign res_if.result_count = res_count_q;
    assign res_if.result_ovf   = res_ovf_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: hand-computed edge counts per window, checked after each edge.
module tb_pulse_meter;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned WIN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             start = 1'b0;
    logic [WIN_W-1:0] window_len = '0;
    logic             pulse_in = 1'b0;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    pulse_meter_if #(.CNT_W(CNT_W)) res_if ();

    pulse_meter #(
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .start_i     (start),
        .window_len_i(window_len),
        .pulse_in_i  (pulse_in),
        .busy_o      (busy),
        .res_if      (res_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse level presented for edge k (k=0 is the start edge).
    function automatic logic pulse_at(input int mode, input int k);
        case (mode)
            0: return (k % 10) == 5;
            1: return k <= 60;
            2: return k >= 50;
            3: return k >= 51;
            4: return (k % 2) == 1;
            5: return (k == 3) || (k == 7) || (k == 11);
            6: return (k == 3) || (k == 6) || (k == 9) || (k == 13) || (k == 17) ||
                      (k == 21) || (k == 25) || (k == 33) || (k == 36) || (k == 39);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic en_at(input int mode, input int k);
        if (mode == 6) return !((k >= 11) && (k <= 30));
        return 1'b1;
    endfunction

    // Full window with ready held high; 'edges' is where the window must close.
    task automatic measure(input string tag, input int len, input int edges, input int mode,
                           input int exp_cnt, input int exp_ovf);
        res_if.result_ready = 1'b1;
        pulse_in   = pulse_at(mode, 0);
        enable     = 1'b1;
        start      = 1'b1;
        window_len = WIN_W'(len);
        step();
        check({tag, "_busy_start"}, int'(busy), 1);
        start = 1'b0;
        for (int k = 1; k <= edges; k++) begin
            pulse_in = pulse_at(mode, k);
            enable   = en_at(mode, k);
            step();
            if (k == edges - 1) check({tag, "_valid_early"}, int'(res_if.result_valid), 0);
        end
        check({tag, "_valid"}, int'(res_if.result_valid), 1);
        check({tag, "_count"}, int'(res_if.result_count), exp_cnt);
        check({tag, "_ovf"}, int'(res_if.result_ovf), exp_ovf);
        pulse_in = pulse_at(mode, edges + 1);
        enable   = 1'b1;
        step();
        check({tag, "_valid_done"}, int'(res_if.result_valid), 0);
        check({tag, "_busy_done"}, int'(busy), 0);
        pulse_in = 1'b0;
        step();
    endtask

    initial begin
        int seen_valid;
        res_if.result_ready = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(res_if.result_valid), 0);
        check("rst_count", int'(res_if.result_count), 0);
        check("rst_ovf", int'(res_if.result_ovf), 0);
        step();
        rst_n = 1'b1;
        step();

        measure("basic", 100, 100, 0, 10, 0);
        measure("level", 50, 50, 1, 0, 0);
        measure("rise_e50", 50, 50, 2, 1, 0);
        measure("rise_e51", 50, 50, 3, 0, 0);
        measure("sat", 1000, 1000, 4, 255, 1);
        measure("post_sat", 20, 20, 5, 3, 0);
        measure("pause", 40, 60, 6, 6, 0);

        // Backpressure: hold ready low while start and pulse_in churn.
        res_if.result_ready = 1'b0;
        enable     = 1'b1;
        start      = 1'b1;
        window_len = WIN_W'(5);
        step();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pulse_in = (k == 2);
            step();
        end
        check("bp_valid", int'(res_if.result_valid), 1);
        check("bp_count", int'(res_if.result_count), 1);
        for (int i = 0; i < 30; i++) begin
            start      = 1'b1;
            window_len = WIN_W'(3);
            pulse_in   = i[0];
            step();
            check("bp_hold_valid", int'(res_if.result_valid), 1);
            check("bp_hold_count", int'(res_if.result_count), 1);
            check("bp_hold_ovf", int'(res_if.result_ovf), 0);
            check("bp_hold_busy", int'(busy), 1);
        end
        // Start coincident with the handshake must not open a window.
        res_if.result_ready = 1'b1;
        step();
        start = 1'b0;
        check("bp_release_valid", int'(res_if.result_valid), 0);
        check("bp_release_busy", int'(busy), 0);
        check("bp_retained_count", int'(res_if.result_count), 1);
        step();
        check("bp_no_new_window", int'(busy), 0);

        // Reset in the middle of a window.
        pulse_in   = 1'b0;
        start      = 1'b1;
        window_len = WIN_W'(100);
        step();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            pulse_in = pulse_at(0, k);
            step();
        end
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(res_if.result_valid), 0);
        check("mid_rst_count", int'(res_if.result_count), 0);
        check("mid_rst_ovf", int'(res_if.result_ovf), 0);
        step();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 120; k++) begin
            pulse_in = k[0];
            step();
            if (res_if.result_valid) seen_valid = 1;
        end
        check("post_rst_no_valid", seen_valid, 0);

        // Illegal starts.
        pulse_in   = 1'b0;
        start      = 1'b1;
        window_len = '0;
        step();
        check("zero_len_busy", int'(busy), 0);
        enable     = 1'b0;
        window_len = WIN_W'(10);
        step();
        check("no_enable_busy", int'(busy), 0);
        start  = 1'b0;
        enable = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
